// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 VGA timing generator and read side of the
// grayscale frame buffer. Each stored pixel is shown as a SCALE x SCALE
// block. The read address is built incrementally from sub-counters, so there
// is no multiplier or divider. The pipeline has three stages from counter
// state to output pins, and all syncs are delayed in step with the pixel.
module vga_frame_reader #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int CAP_HSIZE = 160,
  parameter int CAP_VSIZE = 120,
  parameter int SCALE     = 4,
  parameter int ADDR_BITS = 16
) (
  input  logic                 pclk,
  input  logic                 rst_n,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [7:0]           rd_data,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [7:0]           pixel,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int IMG_H   = CAP_HSIZE * SCALE;
  localparam int IMG_V   = CAP_VSIZE * SCALE;

  // Counter widths must hold both the full line/frame count and the image
  // bound, since a stored image may be wider than the raster.
  localparam int HC_W  = $clog2((H_TOTAL > IMG_H) ? H_TOTAL : IMG_H + 1);
  localparam int VC_W  = $clog2((V_TOTAL > IMG_V) ? V_TOTAL : IMG_V + 1);
  localparam int SUB_W = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HC_W-1:0] H_LAST      = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_VIS_END   = HC_W'(H_VISIBLE);
  localparam logic [HC_W-1:0] H_IMG_END   = HC_W'(IMG_H);
  localparam logic [HC_W-1:0] H_SYNC_BEG  = HC_W'(H_VISIBLE + H_FP);
  localparam logic [HC_W-1:0] H_SYNC_END  = HC_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] V_LAST      = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_VIS_END   = VC_W'(V_VISIBLE);
  localparam logic [VC_W-1:0] V_IMG_END   = VC_W'(IMG_V);
  localparam logic [VC_W-1:0] V_SYNC_BEG  = VC_W'(V_VISIBLE + V_FP);
  localparam logic [VC_W-1:0] V_SYNC_END  = VC_W'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [SUB_W-1:0] SUB_LAST   = SUB_W'(SCALE - 1);
  localparam logic [ADDR_BITS-1:0] ROW_STEP = ADDR_BITS'(CAP_HSIZE);

  // Number of flag pipeline stages between counters and output registers.
  localparam int FLAG_STAGES = 2;

  // Per-position timing flags carried down the pipeline beside the read.
  typedef struct packed {
    logic vis;     // inside the visible raster
    logic img;     // inside the replicated stored image
    logic hs_act;  // horizontal sync pulse active
    logic vs_act;  // vertical sync pulse active
    logic origin;  // position (0,0)
  } flags_t;

  // Stage 0 state: raster position plus incremental address terms.
  logic [HC_W-1:0]      h_cnt_reg, h_cnt_next;
  logic [VC_W-1:0]      v_cnt_reg, v_cnt_next;
  logic [SUB_W-1:0]     h_sub_reg, h_sub_next;
  logic [SUB_W-1:0]     v_sub_reg, v_sub_next;
  logic [ADDR_BITS-1:0] col_idx_reg, col_idx_next;
  logic [ADDR_BITS-1:0] row_base_reg, row_base_next;

  logic                 line_end;
  flags_t               flags_s0;
  logic [ADDR_BITS-1:0] addr_s0;

  flags_t flag_pipe_reg [1:FLAG_STAGES];

  // Next raster position and next address terms; h_sub/v_sub count the
  // replicas of one stored pixel, col_idx/row_base step once per SCALE.
  always_comb begin
    line_end      = (h_cnt_reg == H_LAST);
    h_cnt_next    = h_cnt_reg + 1'b1;
    h_sub_next    = h_sub_reg + 1'b1;
    col_idx_next  = col_idx_reg;
    v_cnt_next    = v_cnt_reg;
    v_sub_next    = v_sub_reg;
    row_base_next = row_base_reg;
    if (h_sub_reg == SUB_LAST) begin
      h_sub_next   = '0;
      col_idx_next = col_idx_reg + 1'b1;
    end
    if (line_end) begin
      h_cnt_next   = '0;
      h_sub_next   = '0;
      col_idx_next = '0;
      if (v_cnt_reg == V_LAST) begin
        v_cnt_next    = '0;
        v_sub_next    = '0;
        row_base_next = '0;
      end else begin
        v_cnt_next = v_cnt_reg + 1'b1;
        if (v_sub_reg == SUB_LAST) begin
          v_sub_next    = '0;
          row_base_next = row_base_reg + ROW_STEP;
        end else begin
          v_sub_next = v_sub_reg + 1'b1;
        end
      end
    end
  end

  // Stage 0 register: raster counters and address terms.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt_reg    <= '0;
      v_cnt_reg    <= '0;
      h_sub_reg    <= '0;
      v_sub_reg    <= '0;
      col_idx_reg  <= '0;
      row_base_reg <= '0;
    end else begin
      h_cnt_reg    <= h_cnt_next;
      v_cnt_reg    <= v_cnt_next;
      h_sub_reg    <= h_sub_next;
      v_sub_reg    <= v_sub_next;
      col_idx_reg  <= col_idx_next;
      row_base_reg <= row_base_next;
    end
  end

  // Decode the current position into timing flags and the read address.
  always_comb begin
    flags_s0.vis    = (h_cnt_reg < H_VIS_END) && (v_cnt_reg < V_VIS_END);
    flags_s0.img    = (h_cnt_reg < H_IMG_END) && (v_cnt_reg < V_IMG_END);
    flags_s0.hs_act = (h_cnt_reg >= H_SYNC_BEG) && (h_cnt_reg < H_SYNC_END);
    flags_s0.vs_act = (v_cnt_reg >= V_SYNC_BEG) && (v_cnt_reg < V_SYNC_END);
    flags_s0.origin = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    addr_s0         = row_base_reg + col_idx_reg;
  end

  // Stage 1: issue the read; the address holds outside the image so it
  // never leaves the stored range.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en            <= 1'b0;
      rd_addr          <= '0;
      flag_pipe_reg[1] <= '0;
    end else begin
      rd_en            <= flags_s0.img;
      flag_pipe_reg[1] <= flags_s0;
      if (flags_s0.img) begin
        rd_addr <= addr_s0;
      end
    end
  end

  // Later flag stages: delay the flags while the read data comes back.
  generate
    for (genvar gi = 2; gi <= FLAG_STAGES; gi++) begin : g_flag_delay
      // Shift flags one stage further.
      always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
          flag_pipe_reg[gi] <= '0;
        end else begin
          flag_pipe_reg[gi] <= flag_pipe_reg[gi-1];
        end
      end
    end
  endgenerate

  // Stage 3: output registers; the pixel is blanked outside the image.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      pixel       <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= ~flag_pipe_reg[FLAG_STAGES].hs_act;
      vsync       <= ~flag_pipe_reg[FLAG_STAGES].vs_act;
      de          <= flag_pipe_reg[FLAG_STAGES].vis;
      frame_start <= flag_pipe_reg[FLAG_STAGES].origin;
      if (flag_pipe_reg[FLAG_STAGES].vis && flag_pipe_reg[FLAG_STAGES].img) begin
        pixel <= rd_data;
      end else begin
        pixel <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Testbench for vga_frame_reader: three instances (full VGA timing, a small
// raster whose image fills it, and a small raster with a reduced image) are
// checked every cycle against an arithmetic model of position -> outputs.
module tb_vga_frame_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // DUT A: default 640x480 timing with a 160x120 image at x4.
  logic        a_rd_en, a_hsync, a_vsync, a_de, a_frame_start;
  logic [15:0] a_rd_addr;
  logic [7:0]  a_rd_data = 8'd0;
  logic [7:0]  a_pixel;
  // DUT B: 16x12 visible raster, 4x3 image at x4 fills it.
  logic        b_rd_en, b_hsync, b_vsync, b_de, b_frame_start;
  logic [15:0] b_rd_addr;
  logic [7:0]  b_rd_data = 8'd0;
  logic [7:0]  b_pixel;
  // DUT C: same raster as B, 3x2 image at x2 covers only 6x4.
  logic        c_rd_en, c_hsync, c_vsync, c_de, c_frame_start;
  logic [15:0] c_rd_addr;
  logic [7:0]  c_rd_data = 8'd0;
  logic [7:0]  c_pixel;

  vga_frame_reader dut_a (
    .pclk(clk), .rst_n(rst_n), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .hsync(a_hsync), .vsync(a_vsync), .de(a_de),
    .pixel(a_pixel), .frame_start(a_frame_start));

  vga_frame_reader #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CAP_HSIZE(4), .CAP_VSIZE(3), .SCALE(4), .ADDR_BITS(16)
  ) dut_b (
    .pclk(clk), .rst_n(rst_n), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .hsync(b_hsync), .vsync(b_vsync), .de(b_de),
    .pixel(b_pixel), .frame_start(b_frame_start));

  vga_frame_reader #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_VISIBLE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .CAP_HSIZE(3), .CAP_VSIZE(2), .SCALE(2), .ADDR_BITS(16)
  ) dut_c (
    .pclk(clk), .rst_n(rst_n), .rd_en(c_rd_en), .rd_addr(c_rd_addr),
    .rd_data(c_rd_data), .hsync(c_hsync), .vsync(c_vsync), .de(c_de),
    .pixel(c_pixel), .frame_start(c_frame_start));

  // Frame buffer models: data is the low address byte, one cycle after a read.
  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_rd_addr[7:0];
    if (b_rd_en) b_rd_data <= b_rd_addr[7:0];
    if (c_rd_en) c_rd_data <= c_rd_addr[7:0];
  end

  // Rising edges since reset release; counters hold position cyc.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic        rden;
    logic        chk_addr;
    logic [7:0]  pix;
    logic [15:0] addr;
  } exp_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, got, want);
    end
  endtask

  // Expected outputs after k rising edges: outputs show position k-3, the
  // read port shows position k-1; address = (v/scale)*width + h/scale.
  function automatic exp_t model(input bit in_rst, input int k,
                                 input int hv, input int hfp, input int hsw, input int hbp,
                                 input int vv, input int vfp, input int vsw, input int vbp,
                                 input int cw, input int ch, input int sc);
    exp_t e;
    int ht, vt, p, h, v, a;
    bit img;
    ht = hv + hfp + hsw + hbp;
    vt = vv + vfp + vsw + vbp;
    e.hs = 1'b1; e.vs = 1'b1; e.de = 1'b0; e.fs = 1'b0;
    e.rden = 1'b0; e.chk_addr = 1'b1; e.pix = 8'd0; e.addr = 16'd0;
    if (in_rst) return e;
    if (k >= 1) begin
      p = k - 1; h = p % ht; v = (p / ht) % vt;
      e.rden = (h < cw * sc) && (v < ch * sc);
      e.chk_addr = e.rden;
      e.addr = 16'((v / sc) * cw + h / sc);
    end
    if (k >= 3) begin
      p = k - 3; h = p % ht; v = (p / ht) % vt;
      img = (h < cw * sc) && (v < ch * sc);
      a = (v / sc) * cw + h / sc;
      e.de = (h < hv) && (v < vv);
      e.hs = !((h >= hv + hfp) && (h < hv + hfp + hsw));
      e.vs = !((v >= vv + vfp) && (v < vv + vfp + vsw));
      e.fs = (h == 0) && (v == 0);
      e.pix = (e.de && img) ? 8'(a) : 8'd0;
    end
    return e;
  endfunction

  task automatic check_inst(input string n, input exp_t e,
                            input logic hs, input logic vs, input logic de_i, input logic fs,
                            input logic [7:0] pix, input logic rden, input logic [15:0] addr,
                            input int max_addr);
    check({n, ".hsync"}, hs, e.hs);
    check({n, ".vsync"}, vs, e.vs);
    check({n, ".de"}, de_i, e.de);
    check({n, ".frame_start"}, fs, e.fs);
    check({n, ".pixel"}, pix, e.pix);
    check({n, ".rd_en"}, rden, e.rden);
    if (e.chk_addr) check({n, ".rd_addr"}, addr, e.addr);
    n_cmp++;
    if (int'(addr) > max_addr) begin
      n_bad++;
      $display("FAIL %s.rd_addr_range at cyc %0d: got %0d, expected <= %0d", n, cyc, addr, max_addr);
    end
  endtask

  // Compare process: model checks on every falling edge plus literal pins.
  initial begin
    bit a_prev_de, a_prev_hs, a_rise_seen, b_prev_vs, b_fs_seen;
    int a_rise_cyc, a_hs_run, b_vs_run, b_fs_last;
    a_prev_de = 0; a_prev_hs = 1; a_rise_seen = 0; b_prev_vs = 1; b_fs_seen = 0;
    a_rise_cyc = 0; a_hs_run = 0; b_vs_run = 0; b_fs_last = 0;
    forever begin
      @(negedge clk);
      check_inst("A", model(!rst_n, cyc, 640, 16, 96, 48, 480, 10, 2, 33, 160, 120, 4),
                 a_hsync, a_vsync, a_de, a_frame_start, a_pixel, a_rd_en, a_rd_addr, 19199);
      check_inst("B", model(!rst_n, cyc, 16, 2, 4, 3, 12, 1, 2, 2, 4, 3, 4),
                 b_hsync, b_vsync, b_de, b_frame_start, b_pixel, b_rd_en, b_rd_addr, 11);
      check_inst("C", model(!rst_n, cyc, 16, 2, 4, 3, 12, 1, 2, 2, 3, 2, 2),
                 c_hsync, c_vsync, c_de, c_frame_start, c_pixel, c_rd_en, c_rd_addr, 5);
      if (!rst_n) begin
        a_prev_de = 0; a_prev_hs = 1; a_rise_seen = 0; a_hs_run = 0;
        b_prev_vs = 1; b_vs_run = 0; b_fs_seen = 0;
      end else begin
        // Hand-computed expectations.
        if (cyc == 3)    check("lit.a_frame_start_first", a_frame_start, 1);
        if (cyc == 4)    check("lit.a_frame_start_one_cycle", a_frame_start, 0);
        if (cyc == 4)    check("lit.a_addr_h3", a_rd_addr, 0);
        if (cyc == 5)    check("lit.a_addr_h4", a_rd_addr, 1);
        if (cyc == 640)  check("lit.a_addr_h639", a_rd_addr, 159);
        if (cyc == 641)  check("lit.a_rden_h640", a_rd_en, 0);
        if (cyc == 3040) check("lit.a_addr_line3_h639", a_rd_addr, 159);
        if (cyc == 3201) check("lit.a_addr_line4_h0", a_rd_addr, 160);
        if (cyc == 8)    check("lit.a_pixel_h5", a_pixel, 1);
        if (cyc == 291)  check("lit.b_addr_max", b_rd_addr, 11);
        if (cyc == 83)   check("lit.c_pixel_5_3", c_pixel, 5);
        if (cyc == 9)    check("lit.c_pixel_outside", c_pixel, 0);
        if (cyc == 9)    check("lit.c_de_outside", c_de, 1);
        if (cyc == 7)    check("lit.c_rden_outside", c_rd_en, 0);
        // Line structure of A: hsync falls 656 after de rises, low 96.
        if (a_de && !a_prev_de) begin a_rise_seen = 1; a_rise_cyc = cyc; end
        if (!a_hsync && a_prev_hs && a_rise_seen)
          check("lit.a_de_to_hsync", cyc - a_rise_cyc, 656);
        if (!a_hsync) a_hs_run++;
        else if (a_hs_run > 0) begin check("lit.a_hsync_width", a_hs_run, 96); a_hs_run = 0; end
        // Frame structure of B: vsync low two 25-pixel lines, frames 425 apart.
        if (!b_vsync) b_vs_run++;
        else if (b_vs_run > 0) begin check("lit.b_vsync_width", b_vs_run, 50); b_vs_run = 0; end
        if (b_frame_start) begin
          if (b_fs_seen) check("lit.b_frame_period", cyc - b_fs_last, 425);
          b_fs_seen = 1; b_fs_last = cyc;
        end
        a_prev_de = a_de; a_prev_hs = a_hsync; b_prev_vs = b_vsync;
      end
    end
  end

  // Stimulus: reset, run, reset mid-line (checked asynchronously), run again.
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20000 && cyc < 4100; i++) @(negedge clk);
    check("run1_reached", (cyc >= 4100) ? 1 : 0, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.a_hsync", a_hsync, 1);
    check("async_rst.a_vsync", a_vsync, 1);
    check("async_rst.a_de", a_de, 0);
    check("async_rst.a_pixel", a_pixel, 0);
    check("async_rst.a_rd_en", a_rd_en, 0);
    check("async_rst.a_rd_addr", a_rd_addr, 0);
    check("async_rst.a_frame_start", a_frame_start, 0);
    check("async_rst.b_de", b_de, 0);
    check("async_rst.c_rd_en", c_rd_en, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 20000 && cyc < 3300; i++) @(negedge clk);
    check("run2_reached", (cyc >= 3300) ? 1 : 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
